// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one-word instruction register fed from a
// combinational instruction memory. The PC advances sequentially with wrap
// at MEM_BYTES, and redirects can be accepted in any state except IDLE.
//
// Handshake: ir_valid/ir_ready follow strict valid/ready semantics.
// - ir_valid is high only while the FSM is in VALID.
// - While ir_valid is high, ir_instr and ir_pc are stable.
// - A transfer happens on a rising edge where ir_valid && ir_ready, unless an
//   accepted redirect in the same cycle discards the instruction instead.
module instr_fetch_unit #(
    parameter int unsigned MEM_BYTES = 64,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_addr,
    output logic        mem_iord,
    input  logic [31:0] mem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir_instr,
    output logic [31:0] ir_pc,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        FAULT = 2'd3
    } state_t;

    // Sequential increment wraps inside the memory; the last legal word
    // address bounds redirect targets.
    localparam logic [31:0] PC_MASK   = 32'(MEM_BYTES - 1);
    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_instr_q, ir_instr_d;
    logic [31:0] ir_pc_q, ir_pc_d;
    logic        fault_q, fault_d;

    logic        redirect_take;
    logic        redirect_bad;

    // Redirect qualification: ignored in IDLE, bad when misaligned or past the
    // last word of the memory.
    always_comb begin
        redirect_take = redirect_valid && (state_q != IDLE);
        redirect_bad  = (redirect_pc[1:0] != 2'b00) || (redirect_pc > LAST_WORD);
    end

    // Next-state logic; a redirect outranks both the fetch latch and the
    // ir handshake.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_instr_d = ir_instr_q;
        ir_pc_d    = ir_pc_q;
        fault_d    = fault_q;

        if (redirect_take) begin
            if (redirect_bad) begin
                // A bad target leaves pc untouched and parks the unit in FAULT.
                fault_d = 1'b1;
                state_d = FAULT;
            end else begin
                fault_d = 1'b0;
                pc_d    = redirect_pc;
                state_d = FETCH;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    ir_instr_d = mem_data;
                    ir_pc_d    = pc_q;
                    state_d    = VALID;
                end
                VALID: begin
                    if (ir_ready) begin
                        pc_d    = (pc_q + 32'd4) & PC_MASK;
                        state_d = FETCH;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, pc, instruction register and fault flag; reset aborts at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            ir_instr_q <= 32'd0;
            ir_pc_q    <= 32'd0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_instr_q <= ir_instr_d;
            ir_pc_q    <= ir_pc_d;
            fault_q    <= fault_d;
        end
    end

    // Outputs are decoded directly from registered state.
    always_comb begin
        mem_addr    = pc_q;
        mem_iord    = (state_q == FETCH);
        ir_valid    = (state_q == VALID);
        ir_instr    = ir_instr_q;
        ir_pc       = ir_pc_q;
        fetch_fault = fault_q;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 16-word instruction memory model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic        mem_iord;
    logic [31:0] mem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir_instr;
    logic [31:0] ir_pc;
    logic        fetch_fault;

    logic [31:0] mem [16];

    int tests_run = 0;
    int tests_failed = 0;

    instr_fetch_unit #(
        .MEM_BYTES(64),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_addr      (mem_addr),
        .mem_iord      (mem_iord),
        .mem_data      (mem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .ir_valid      (ir_valid),
        .ir_ready      (ir_ready),
        .ir_instr      (ir_instr),
        .ir_pc         (ir_pc),
        .fetch_fault   (fetch_fault)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory
    assign mem_data = mem[mem_addr[5:2]];

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset across one edge; returns just after release (IDLE).
    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        tests_run++;
        if ({ir_valid, mem_iord, fetch_fault, mem_addr, ir_instr, ir_pc} !== {3'b000, 32'd0, 32'd0, 32'd0}) begin
            tests_failed++;
            $display("FAIL reset_no_clock: valid=%b iord=%b fault=%b addr=%h instr=%h pc=%h, want all zero",
                     ir_valid, mem_iord, fetch_fault, mem_addr, ir_instr, ir_pc);
        end
        step();
        step();
        tests_run++;
        if ({ir_valid, mem_iord, fetch_fault, mem_addr, ir_instr, ir_pc} !== {3'b000, 32'd0, 32'd0, 32'd0}) begin
            tests_failed++;
            $display("FAIL reset_clocked: valid=%b iord=%b fault=%b addr=%h instr=%h pc=%h, want all zero",
                     ir_valid, mem_iord, fetch_fault, mem_addr, ir_instr, ir_pc);
        end
    endtask

    task automatic test_basic_fetch();
        ir_ready = 1'b1;
        rst_n = 1'b1;
        tests_run++;
        if ({ir_valid, mem_iord} !== 2'b00) begin
            tests_failed++;
            $display("FAIL idle_cycle: valid=%b iord=%b, want 0 0", ir_valid, mem_iord);
        end
        step();
        tests_run++;
        if ({ir_valid, mem_iord, mem_addr} !== {2'b01, 32'h0}) begin
            tests_failed++;
            $display("FAIL first_fetch: valid=%b iord=%b addr=%h, want 0 1 00000000", ir_valid, mem_iord, mem_addr);
        end
        step();
        tests_run++;
        if ({ir_valid, mem_iord, ir_pc, ir_instr} !== {2'b10, 32'h0, 32'h0000_0013}) begin
            tests_failed++;
            $display("FAIL first_valid: valid=%b iord=%b pc=%h instr=%h, want 1 0 00000000 00000013",
                     ir_valid, mem_iord, ir_pc, ir_instr);
        end
        step();
        tests_run++;
        if ({ir_valid, mem_iord, mem_addr, ir_pc} !== {2'b01, 32'h4, 32'h0}) begin
            tests_failed++;
            $display("FAIL second_fetch: valid=%b iord=%b addr=%h pc=%h, want 0 1 00000004 00000000",
                     ir_valid, mem_iord, mem_addr, ir_pc);
        end
        step();
        tests_run++;
        if ({ir_valid, ir_pc, ir_instr} !== {1'b1, 32'h4, 32'h0010_0093}) begin
            tests_failed++;
            $display("FAIL second_valid: valid=%b pc=%h instr=%h, want 1 00000004 00100093", ir_valid, ir_pc, ir_instr);
        end
    endtask

    task automatic test_stall();
        do_reset();
        ir_ready = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if ({ir_valid, mem_iord, mem_addr, ir_pc, ir_instr} !== {2'b10, 32'h0, 32'h0, 32'h0000_0013}) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: valid=%b iord=%b addr=%h pc=%h instr=%h, want 1 0 0 0 00000013",
                         i, ir_valid, mem_iord, mem_addr, ir_pc, ir_instr);
            end
            step();
        end
        ir_ready = 1'b1;
        step();
        tests_run++;
        if ({ir_valid, mem_iord, mem_addr} !== {2'b01, 32'h4}) begin
            tests_failed++;
            $display("FAIL stall_release: valid=%b iord=%b addr=%h, want 0 1 00000004", ir_valid, mem_iord, mem_addr);
        end
    endtask

    task automatic test_wrap();
        for (int k = 1; k < 16; k++) begin
            tests_run++;
            if ({mem_iord, mem_addr} !== {1'b1, 32'(k * 4)}) begin
                tests_failed++;
                $display("FAIL seq_fetch[%0d]: iord=%b addr=%h, want 1 %h", k, mem_iord, mem_addr, 32'(k * 4));
            end
            step();
            tests_run++;
            if ({ir_valid, ir_pc, ir_instr} !== {1'b1, 32'(k * 4), mem[k]}) begin
                tests_failed++;
                $display("FAIL seq_valid[%0d]: valid=%b pc=%h instr=%h, want 1 %h %h",
                         k, ir_valid, ir_pc, ir_instr, 32'(k * 4), mem[k]);
            end
            step();
        end
        tests_run++;
        if ({mem_iord, fetch_fault, mem_addr} !== {2'b10, 32'h0}) begin
            tests_failed++;
            $display("FAIL wrap: iord=%b fault=%b addr=%h, want 1 0 00000000", mem_iord, fetch_fault, mem_addr);
        end
    endtask

    task automatic test_redirect_discard();
        repeat (5) step();
        tests_run++;
        if ({ir_valid, ir_pc} !== {1'b1, 32'h8}) begin
            tests_failed++;
            $display("FAIL reach_pc8: valid=%b pc=%h, want 1 00000008", ir_valid, ir_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        ir_ready       = 1'b1;
        step();
        redirect_valid = 1'b0;
        tests_run++;
        if ({ir_valid, mem_iord, mem_addr, ir_pc} !== {2'b01, 32'h10, 32'h8}) begin
            tests_failed++;
            $display("FAIL redirect_fetch: valid=%b iord=%b addr=%h pc=%h, want 0 1 00000010 00000008",
                     ir_valid, mem_iord, mem_addr, ir_pc);
        end
        step();
        tests_run++;
        if ({ir_valid, ir_pc, ir_instr} !== {1'b1, 32'h10, mem[4]}) begin
            tests_failed++;
            $display("FAIL redirect_valid: valid=%b pc=%h instr=%h, want 1 00000010 %h", ir_valid, ir_pc, ir_instr, mem[4]);
        end
    endtask

    task automatic test_fault();
        ir_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h12;
        step();
        tests_run++;
        if ({fetch_fault, mem_iord, ir_valid, mem_addr, ir_pc} !== {3'b100, 32'h10, 32'h10}) begin
            tests_failed++;
            $display("FAIL fault_misaligned: fault=%b iord=%b valid=%b addr=%h pc=%h, want 1 0 0 00000010 00000010",
                     fetch_fault, mem_iord, ir_valid, mem_addr, ir_pc);
        end
        redirect_pc = 32'h40;
        step();
        tests_run++;
        if ({fetch_fault, mem_iord, ir_valid, mem_addr} !== {3'b100, 32'h10}) begin
            tests_failed++;
            $display("FAIL fault_range: fault=%b iord=%b valid=%b addr=%h, want 1 0 0 00000010",
                     fetch_fault, mem_iord, ir_valid, mem_addr);
        end
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if ({fetch_fault, mem_iord, ir_valid} !== 3'b100) begin
                tests_failed++;
                $display("FAIL fault_sticky[%0d]: fault=%b iord=%b valid=%b, want 1 0 0", i, fetch_fault, mem_iord, ir_valid);
            end
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        step();
        redirect_valid = 1'b0;
        tests_run++;
        if ({fetch_fault, mem_iord, mem_addr} !== {2'b01, 32'h20}) begin
            tests_failed++;
            $display("FAIL fault_clear: fault=%b iord=%b addr=%h, want 0 1 00000020", fetch_fault, mem_iord, mem_addr);
        end
        ir_ready = 1'b1;
        step();
        tests_run++;
        if ({ir_valid, ir_pc, ir_instr} !== {1'b1, 32'h20, mem[8]}) begin
            tests_failed++;
            $display("FAIL fault_recover: valid=%b pc=%h instr=%h, want 1 00000020 %h", ir_valid, ir_pc, ir_instr, mem[8]);
        end
    endtask

    task automatic test_mid_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h18;
        step();
        redirect_valid = 1'b0;
        tests_run++;
        if ({mem_iord, mem_addr} !== {1'b1, 32'h18}) begin
            tests_failed++;
            $display("FAIL fetch_0x18: iord=%b addr=%h, want 1 00000018", mem_iord, mem_addr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({ir_valid, mem_iord, fetch_fault, mem_addr, ir_instr, ir_pc} !== {3'b000, 32'd0, 32'd0, 32'd0}) begin
            tests_failed++;
            $display("FAIL async_reset: valid=%b iord=%b fault=%b addr=%h instr=%h pc=%h, want all zero",
                     ir_valid, mem_iord, fetch_fault, mem_addr, ir_instr, ir_pc);
        end
        step();
        rst_n          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        tests_run++;
        if ({ir_valid, mem_iord, mem_addr} !== {2'b00, 32'h0}) begin
            tests_failed++;
            $display("FAIL restart_idle: valid=%b iord=%b addr=%h, want 0 0 00000000", ir_valid, mem_iord, mem_addr);
        end
        step();
        redirect_valid = 1'b0;
        tests_run++;
        if ({mem_iord, fetch_fault, mem_addr} !== {2'b10, 32'h0}) begin
            tests_failed++;
            $display("FAIL idle_redirect_ignored: iord=%b fault=%b addr=%h, want 1 0 00000000", mem_iord, fetch_fault, mem_addr);
        end
        step();
        tests_run++;
        if ({ir_valid, ir_pc, ir_instr} !== {1'b1, 32'h0, 32'h0000_0013}) begin
            tests_failed++;
            $display("FAIL restart_valid: valid=%b pc=%h instr=%h, want 1 00000000 00000013", ir_valid, ir_pc, ir_instr);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hA500_0000 | 32'(i * 4);
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0010_0093;
        rst_n          = 1'b0;
        ir_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        test_reset();
        test_basic_fetch();
        test_stall();
        test_wrap();
        test_redirect_discard();
        test_fault();
        test_mid_reset();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
